// File: rtl/dec_pkg.sv
// dec_pkg: shared constants and types for the 5-to-32 register select decoder.
//   DEC_ADR_W   - register address width
//   DEC_OUT_W   - one-hot select width
//   DEC_RST_VAL - select vector value while in reset (nothing selected)
package dec_pkg;

   localparam int DEC_ADR_W = 5;
   localparam int DEC_OUT_W = 32;
   localparam logic [DEC_OUT_W-1:0] DEC_RST_VAL = 32'h0;

   typedef logic [DEC_OUT_W-1:0] dec_sel_t;

endpackage : dec_pkg

// File: rtl/dec_predecode.sv
// dec_predecode: combinational N-to-2^N one-hot decoder used as one level of
// the two-level address decode.
// Ports:
//   sel_i    [N-1:0]     binary select
//   onehot_o [2**N-1:0]  onehot_o[k] = 1 iff sel_i == k
module dec_predecode #(
   parameter int N = 2
) (
   input  logic [N-1:0]    sel_i,
   output logic [2**N-1:0] onehot_o
);

   always_comb begin
      onehot_o        = '0;
      onehot_o[sel_i] = 1'b1;
   end

endmodule : dec_predecode

// File: rtl/dec5_to_32.sv
// dec5_to_32: registered 5-to-32 one-hot register-file write select.
// Adr is decoded through a 2-to-4 (Adr[4:3]) and a 3-to-8 (Adr[2:0])
// predecoder, combined in an AND matrix and registered on Clk, so Out is
// valid one cycle after Adr is sampled.
// Ports:
//   Clk  system clock, rising edge
//   Rst  asynchronous active-high reset, clears Out
//   Adr  [4:0]  register address
//   Out  [31:0] registered one-hot select
// Build option:
//   DEC_ZERO_MASK_EN - when defined, Adr==0 decodes to no select so the
//                      MIPS $zero register is never written.
module dec5_to_32
   import dec_pkg::*;
#(
   parameter int ADR_W = DEC_ADR_W
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic [ADR_W-1:0]    Adr,
   output logic [2**ADR_W-1:0] Out
);

   localparam int OUT_W = 2**ADR_W;

   logic [3:0]       pre_hi;
   logic [7:0]       pre_lo;
   logic [OUT_W-1:0] dec_full;
   logic [OUT_W-1:0] out_d;
   logic [OUT_W-1:0] out_q;

   dec_predecode #(.N(2)) u_pre_hi (
      .sel_i    (Adr[ADR_W-1:3]),
      .onehot_o (pre_hi)
   );

   dec_predecode #(.N(3)) u_pre_lo (
      .sel_i    (Adr[2:0]),
      .onehot_o (pre_lo)
   );

   // Out[8*h+l] selected when high group h and low index l are both active.
   for (genvar h = 0; h < 4; h++) begin : g_hi
      for (genvar l = 0; l < 8; l++) begin : g_lo
         assign dec_full[8*h+l] = pre_hi[h] & pre_lo[l];
      end
   end

`ifdef DEC_ZERO_MASK_EN
   // Bit 0 only ever selects $zero, so dropping it masks that address alone.
   assign out_d = {dec_full[OUT_W-1:1], 1'b0};
`else
   assign out_d = dec_full;
`endif

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         out_q <= DEC_RST_VAL;
      end else begin
         out_q <= out_d;
      end
   end

   assign Out = out_q;

endmodule : dec5_to_32

// File: tb/tb_dec5_to_32.sv
// tb_dec5_to_32: directed self-checking bench for dec5_to_32.
// Inputs change on the falling edge; Out is sampled 1 ns after the rising edge.
module tb_dec5_to_32;

   logic        clk_sys;
   logic        rst;
   logic [4:0]  adr;
   logic [31:0] out_w;

   int n_checks = 0;
   int n_fail   = 0;

   dec5_to_32 dut (
      .Clk (clk_sys),
      .Rst (rst),
      .Adr (adr),
      .Out (out_w)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 32'h%08h, expected 32'h%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Hand model of the decode for one address.
   function automatic logic [31:0] exp_sel(input logic [4:0] a);
      logic [31:0] one;
      one = 32'h1;
`ifdef DEC_ZERO_MASK_EN
      if (a == 5'd0) return 32'h0;
`endif
      return one << a;
   endfunction

   task automatic drive_and_clock(input logic [4:0] a);
      @(negedge clk_sys);
      adr = a;
      @(posedge clk_sys);
      #1;
   endtask

   initial begin
      logic [4:0] seq [4];
      seq[0] = 5'd0; seq[1] = 5'd1; seq[2] = 5'd2; seq[3] = 5'd3;

      // Reset held with a live address
      rst = 1'b1;
      adr = 5'b00101;
      #1;
      chk("rst_immediate", out_w, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_sys);
         #1;
         chk("rst_hold", out_w, 32'h0);
      end
      @(negedge clk_sys);
      rst = 1'b0;
      #1;
      chk("rst_release_pre_edge", out_w, 32'h0);
      @(posedge clk_sys);
      #1;
      chk("rst_release_first_edge", out_w, 32'h0000_0020);

      // Consecutive edges 0,1,2,3 with one-cycle latency
      @(negedge clk_sys);
      adr = seq[0];
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_sys);
         #1;
         chk("seq", out_w, exp_sel(seq[i]));
         @(negedge clk_sys);
         if (i < 3) adr = seq[i+1];
      end
      chk("seq_adr0_literal",
`ifdef DEC_ZERO_MASK_EN
          32'h0,
`else
          32'h1,
`endif
          exp_sel(5'd0));

      // Full sweep and one-hot property
      for (int i = 0; i < 32; i++) begin
         drive_and_clock(5'(i));
         chk("sweep", out_w, exp_sel(5'(i)));
`ifdef DEC_ZERO_MASK_EN
         if (i != 0) chk("onehot", 32'($countones(out_w)), 32'd1);
`else
         chk("onehot", 32'($countones(out_w)), 32'd1);
`endif
      end

      // Boundaries
      drive_and_clock(5'b11111);
      chk("bound_msb", out_w, 32'h8000_0000);
      drive_and_clock(5'b10000);
      chk("bound_hi_group", out_w, 32'h0001_0000);
      drive_and_clock(5'b01000);
      chk("bound_group1", out_w, 32'h0000_0100);

      // Mid-cycle toggles only matter at the edge
      @(negedge clk_sys);
      adr = 5'd4;
      #1 adr = 5'd9;
      #1;
      chk("midcycle_hold", out_w, 32'h0000_0100);
      adr = 5'd4;
      @(posedge clk_sys);
      #1;
      chk("midcycle_edge", out_w, 32'h0000_0010);
      adr = 5'd9;
      #1;
      chk("midcycle_after_edge", out_w, 32'h0000_0010);

      // Async reset pulse between edges
      drive_and_clock(5'd10);
      chk("pre_async", out_w, 32'h0000_0400);
      #1 rst = 1'b1;
      #1;
      chk("async_clear", out_w, 32'h0);
      #1 rst = 1'b0;
      #1;
      chk("async_release_hold", out_w, 32'h0);
      @(posedge clk_sys);
      #1;
      chk("async_restore", out_w, 32'h0000_0400);

      // Reset rising together with a clock edge
      @(negedge clk_sys);
      adr = 5'd7;
      @(posedge clk_sys);
      rst = 1'b1;
      #1;
      chk("rst_with_edge", out_w, 32'h0);
      @(negedge clk_sys);
      rst = 1'b0;
      @(posedge clk_sys);
      #1;
      chk("rst_with_edge_recover", out_w, 32'h0000_0080);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_dec5_to_32
